// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with parametrised width/depth, programmable almost-full/almost-empty
// thresholds, occupancy count, sticky error flags and selectable FWFT read mode.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  rd_accept;
  logic                  wr_accept;

  // Flags are decoded from the registered count so they can never lag it.
  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_C);
  assign almost_empty = (count_reg <= AE_C);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A read frees a slot this cycle, so a write into a full FIFO may proceed alongside it.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_reg <= count_reg + (ADDR_WIDTH + 1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR_WIDTH + 1)'(1);
        default: count_reg <= count_reg;
      endcase
      // Setting takes priority over a simultaneous clear.
      if (wr_en && full && !rd_en) begin
        overflow_reg <= 1'b1;
      end else if (clr_err) begin
        overflow_reg <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow_reg <= 1'b1;
      end else if (clr_err) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = mem_reg[rd_ptr_reg];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data_reg <= '0;
        end else if (rd_accept) begin
          rd_data_reg <= mem_reg[rd_ptr_reg];
        end
      end
      assign rd_data = rd_data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a standard and an FWFT instance share stimulus and are
// compared against a queue-based reference model; a monitor pops expected read data.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          full0, empty0, af0, ae0, ov0, uf0;
  logic          full1, empty1, af1, ae1, ov1, uf1;
  logic [AW:0]   count0, count1;

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ov0), .underflow(uf0), .clr_err(clr_err)
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ov1), .underflow(uf1), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Reference model: contents as a queue, sticky flags, last word read out.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  bit            m_ov = 1'b0;
  bit            m_uf = 1'b0;
  logic [DW-1:0] m_last = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : model
    int  n;
    bit  ra, wa;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        exp_q.delete();
        m_ov   = 1'b0;
        m_uf   = 1'b0;
        m_last = '0;
      end else begin
        n  = mq.size();
        ra = rd_en && (n > 0);
        wa = wr_en && ((n < DEPTH) || ra);
        if (wr_en && n == DEPTH && !rd_en) m_ov = 1'b1;
        else if (clr_err) m_ov = 1'b0;
        if (rd_en && n == 0) m_uf = 1'b1;
        else if (clr_err) m_uf = 1'b0;
        if (ra) begin
          m_last = mq.pop_front();
          exp_q.push_back(m_last);
        end
        if (wa) mq.push_back(wr_data);
      end
    end
  end

  // Monitor: whenever the standard instance accepts a read, its registered output is compared.
  initial begin : monitor
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      if (checking && rst && rd_en && !empty0) begin
        #1;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_read", 32'(rd_data0), 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("sb_rd_data", 32'(rd_data0), 32'(e));
        end
      end
    end
  end

  // Flag/count checker on the falling edge, both instances.
  initial begin : flag_checker
    forever begin
      @(negedge clk);
      if (checking && rst) begin
        chk("count_std",  32'(count0), 32'(mq.size()));
        chk("count_fwft", 32'(count1), 32'(mq.size()));
        chk("empty_std",  32'(empty0), 32'(mq.size() == 0));
        chk("empty_fwft", 32'(empty1), 32'(mq.size() == 0));
        chk("full_std",   32'(full0),  32'(mq.size() == DEPTH));
        chk("full_fwft",  32'(full1),  32'(mq.size() == DEPTH));
        chk("af_std",     32'(af0),    32'(mq.size() >= AFL));
        chk("af_fwft",    32'(af1),    32'(mq.size() >= AFL));
        chk("ae_std",     32'(ae0),    32'(mq.size() <= AEL));
        chk("ae_fwft",    32'(ae1),    32'(mq.size() <= AEL));
        chk("ovf_std",    32'(ov0),    32'(m_ov));
        chk("ovf_fwft",   32'(ov1),    32'(m_ov));
        chk("udf_std",    32'(uf0),    32'(m_uf));
        chk("udf_fwft",   32'(uf1),    32'(m_uf));
        chk("rd_hold_std", 32'(rd_data0), 32'(m_last));
        if (mq.size() > 0) chk("fwft_head", 32'(rd_data1), 32'(mq[0]));
      end
    end
  end

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    $display("cyc t=%0t wr=%0b data=0x%02h rd=%0b clr=%0b", $time, w, d, r, c);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin : stim
    logic [DW-1:0] d;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    checking = 1'b1;

    // Mid-run asynchronous reset with five words stored.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    idle();
    chk("pre_reset_count", 32'(count0), 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("rst_count",    32'(count0), 32'd0);
    chk("rst_empty",    32'(empty0), 32'd1);
    chk("rst_full",     32'(full0),  32'd0);
    chk("rst_ae",       32'(ae0),    32'd1);
    chk("rst_ovf",      32'(ov0),    32'd0);
    chk("rst_udf",      32'(uf0),    32'd0);
    chk("rst_rd_data",  32'(rd_data0), 32'd0);
    chk("rst_count_fw", 32'(count1), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fill, then overfill.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    idle();
    chk("overfill_ovf",   32'(ov0),    32'd1);
    chk("overfill_count", 32'(count0), 32'd8);

    // Drain, underflow, clear.
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    chk("drain_udf",     32'(uf0),      32'd1);
    chk("drain_rd_hold", 32'(rd_data0), 32'h08);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    chk("clr_udf", 32'(uf0), 32'd0);
    chk("clr_ovf", 32'(ov0), 32'd0);

    // Simultaneous access at full, then at empty.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    idle();
    chk("full_both_count", 32'(count0), 32'd8);
    chk("full_both_ovf",   32'(ov0),    32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    chk("aa_last", 32'(rd_data0), 32'hAA);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    idle();
    chk("empty_both_count", 32'(count0), 32'd1);
    chk("empty_both_udf",   32'(uf0),    32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    idle();
    chk("empty_both_read", 32'(rd_data0), 32'h55);

    // Wrap-around with interleaved single write/read.
    d = 8'h40;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        cyc(1'b1, d, 1'b0, 1'b0);
        d = d + 8'd1;
      end else begin
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end
    end
    idle();

    // FWFT fall-through of a single word.
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    idle();
    chk("fwft_show", 32'(rd_data1), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    chk("fwft_pop_empty", 32'(empty1), 32'd1);
    chk("fwft_pop_count", 32'(count1), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45),
          ($urandom_range(0, 99) < 5));
    end
    repeat (3) idle();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
